branch_resolve_queue: RTL and testbench

// Holds every fetch-time branch prediction in age order until execute resolves it.

---
 rtl/rv32i_types_pkg.sv | 25 ++
 rtl/brq_storage.sv | 33 +++
 rtl/branch_resolve_queue.sv | 119 +++++++++++
 tb/tb_branch_resolve_queue.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types_pkg.sv
// rv32i_types_pkg
// Shared RV32I word type and the branch-queue entry record.
// word_t      : 32-bit address/data word
// brq_entry_t : one in-flight predicted branch (pc, predicted target,
//               predicted direction, compressed-instruction flag)
// fallthrough : sequential next PC of a branch (+2 compressed, +4 otherwise)
package rv32i_types_pkg;

    localparam int WORD_SIZE = 32;

    typedef logic [WORD_SIZE-1:0] word_t;

    typedef struct packed {
        word_t pc;
        word_t target;
        logic  taken;
        logic  rv32c;
    } brq_entry_t;

    // Address arithmetic wraps at 32 bits by construction of word_t.
    function automatic word_t fallthrough(input word_t pc, input logic rv32c);
        return pc + (rv32c ? word_t'(2) : word_t'(4));
    endfunction

endpackage

// File: rtl/brq_storage.sv
// brq_storage
// DEPTH-entry register file holding predicted branches.
// CLK     in  clock, rising edge
// wr_en   in  write strobe
// wr_idx  in  write slot
// wr_data in  entry to write
// rd_idx  in  read slot (queue head)
// rd_data out entry at rd_idx, combinational read
module brq_storage
    import rv32i_types_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  brq_entry_t               wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output brq_entry_t               rd_data
);

    brq_entry_t mem_reg [DEPTH];

    // Contents need no reset: a slot is only read after it has been written.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_reg[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem_reg[rd_idx];

endmodule

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue
// Age-ordered queue of fetch-time branch predictions. When execute resolves
// the oldest branch, the prediction is compared with the actual outcome and
// registered mispredict/redirect and predictor-update pulses are produced.
// CLK, nRST                      clock / async active-low reset
// push_valid/ready/pc/taken/target/rv32c  fetch-side push port
// resolve_valid/taken/target     execute-side resolve of the oldest entry
// flush                          external squash, clears the queue
// mispredict, redirect_pc        registered mispredict pulse + correct next PC
// update_predictor, pc_to_update, update_addr, branch_result  predictor update
// count                          current occupancy
// underflow_err                  registered pulse: resolve while empty
module branch_resolve_queue
    import rv32i_types_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  word_t                    push_pc,
    input  logic                     push_taken,
    input  word_t                    push_target,
    input  logic                     push_rv32c,
    input  logic                     resolve_valid,
    input  logic                     resolve_taken,
    input  word_t                    resolve_target,
    input  logic                     flush,
    output logic                     mispredict,
    output word_t                    redirect_pc,
    output logic                     update_predictor,
    output word_t                    pc_to_update,
    output word_t                    update_addr,
    output logic                     branch_result,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     underflow_err
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0] head_reg, head_next;
    logic [AW:0] tail_reg, tail_next;

    brq_entry_t head_entry;
    brq_entry_t push_entry;

    logic empty, full;
    logic do_resolve, do_push, mis, clear;

    assign empty = (head_reg == tail_reg);
    assign full  = (head_reg[AW] != tail_reg[AW]) &&
                   (head_reg[AW-1:0] == tail_reg[AW-1:0]);

    // Depends only on registered pointers: no path from resolve to push_ready.
    assign push_ready = !full;
    assign count      = tail_reg - head_reg;

    assign do_resolve = resolve_valid && !empty;
    assign mis = (head_entry.taken != resolve_taken) ||
                 (resolve_taken && (head_entry.target != resolve_target));
    // Everything younger than a mispredicted branch is wrong-path.
    assign clear   = flush || (do_resolve && mis);
    assign do_push = push_valid && push_ready && !clear;

    assign push_entry = '{pc: push_pc, target: push_target,
                          taken: push_taken, rv32c: push_rv32c};

    brq_storage #(.DEPTH(DEPTH)) u_storage (
        .CLK     (CLK),
        .wr_en   (do_push),
        .wr_idx  (tail_reg[AW-1:0]),
        .wr_data (push_entry),
        .rd_idx  (head_reg[AW-1:0]),
        .rd_data (head_entry)
    );

    always_comb begin
        head_next = head_reg;
        tail_next = tail_reg;
        if (clear) begin
            head_next = '0;
            tail_next = '0;
        end else begin
            if (do_resolve) head_next = head_reg + 1'b1;
            if (do_push)    tail_next = tail_reg + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            head_reg         <= '0;
            tail_reg         <= '0;
            mispredict       <= 1'b0;
            redirect_pc      <= '0;
            update_predictor <= 1'b0;
            pc_to_update     <= '0;
            update_addr      <= '0;
            branch_result    <= 1'b0;
            underflow_err    <= 1'b0;
        end else begin
            head_reg         <= head_next;
            tail_reg         <= tail_next;
            update_predictor <= do_resolve;
            mispredict       <= do_resolve && mis;
            underflow_err    <= resolve_valid && empty;
            // Data outputs hold their last value between resolves.
            if (do_resolve) begin
                pc_to_update  <= head_entry.pc;
                update_addr   <= resolve_target;
                branch_result <= resolve_taken;
                redirect_pc   <= resolve_taken ? resolve_target
                                               : fallthrough(head_entry.pc, head_entry.rv32c);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_queue.sv
`timescale 1ns/1ps
module tb_branch_resolve_queue;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        push_valid = 1'b0, push_taken = 1'b0, push_rv32c = 1'b0;
    logic [31:0] push_pc = '0, push_target = '0;
    logic        resolve_valid = 1'b0, resolve_taken = 1'b0, flush = 1'b0;
    logic [31:0] resolve_target = '0;
    logic        push_ready, mispredict, update_predictor, branch_result, underflow_err;
    logic [31:0] redirect_pc, pc_to_update, update_addr;
    logic [2:0]  count;

    branch_resolve_queue #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .nRST(nRST),
        .push_valid(push_valid), .push_ready(push_ready), .push_pc(push_pc),
        .push_taken(push_taken), .push_target(push_target), .push_rv32c(push_rv32c),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .resolve_target(resolve_target), .flush(flush),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .update_predictor(update_predictor), .pc_to_update(pc_to_update),
        .update_addr(update_addr), .branch_result(branch_result),
        .count(count), .underflow_err(underflow_err)
    );

    always #5 CLK = ~CLK;

    // Reference model: a plain queue of predictions, oldest first.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        tk;
        logic        c;
    } pred_t;

    typedef struct {
        logic        uf;
        logic        mis;
        logic [31:0] redir;
        logic [31:0] pc;
        logic [31:0] addr;
        logic        res;
    } resp_t;

    pred_t mq[$];
    resp_t expq[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
        end
    endtask

    // One cycle: check occupancy, drive inputs, advance the model.
    task automatic step(input logic pv, input logic [31:0] pc, input logic tk,
                        input logic [31:0] tgt, input logic c, input logic rv,
                        input logic rtk, input logic [31:0] rtgt, input logic fl);
        int    n;
        logic  mis;
        pred_t e;
        resp_t r;
        @(negedge CLK);
        n = mq.size();
        chk("count", {29'b0, count}, n);
        chk("push_ready", {31'b0, push_ready}, (n < DEPTH) ? 1 : 0);
        push_valid = pv; push_pc = pc; push_taken = tk; push_target = tgt;
        push_rv32c = c; resolve_valid = rv; resolve_taken = rtk;
        resolve_target = rtgt; flush = fl;
        $display("cyc t=%0t push=%0b pc=%h tk=%0b tgt=%h c=%0b | res=%0b tk=%0b tgt=%h | flush=%0b n=%0d",
                 $time, pv, pc, tk, tgt, c, rv, rtk, rtgt, fl, n);
        mis = 1'b0;
        if (rv && n == 0) begin
            r = '{uf: 1'b1, mis: 1'b0, redir: '0, pc: '0, addr: '0, res: 1'b0};
            expq.push_back(r);
        end else if (rv) begin
            e   = mq.pop_front();
            mis = (e.tk != rtk) || (rtk && e.tgt != rtgt);
            r.uf    = 1'b0;
            r.mis   = mis;
            r.redir = rtk ? rtgt : e.pc + (e.c ? 32'd2 : 32'd4);
            r.pc    = e.pc;
            r.addr  = rtgt;
            r.res   = rtk;
            expq.push_back(r);
        end
        if (mis || fl) mq.delete();
        else if (pv && n < DEPTH) mq.push_back('{pc: pc, tgt: tgt, tk: tk, c: c});
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic push(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic c);
        step(1, pc, tk, tgt, c, 0, 0, 0, 0);
    endtask
    task automatic resolve(input logic tk, input logic [31:0] tgt);
        step(0, 0, 0, 0, 0, 1, tk, tgt, 0);
    endtask

    // Monitor: pops an expected response whenever the DUT presents one.
    always @(negedge CLK) begin
        resp_t r;
        if (nRST) begin
            if (update_predictor || underflow_err) begin
                if (expq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_output: upd=%0b uf=%0b expected none", update_predictor, underflow_err);
                end else begin
                    r = expq.pop_front();
                    chk("underflow_err", {31'b0, underflow_err}, {31'b0, r.uf});
                    chk("update_predictor", {31'b0, update_predictor}, {31'b0, !r.uf});
                    chk("mispredict", {31'b0, mispredict}, {31'b0, r.mis});
                    if (!r.uf) begin
                        chk("pc_to_update", pc_to_update, r.pc);
                        chk("update_addr", update_addr, r.addr);
                        chk("branch_result", {31'b0, branch_result}, {31'b0, r.res});
                        if (r.mis) chk("redirect_pc", redirect_pc, r.redir);
                    end
                end
            end else begin
                chk("mispredict_idle", {31'b0, mispredict}, 0);
            end
        end
    end

    initial begin
        logic [31:0] tg [4];
        tg[0] = 32'h200; tg[1] = 32'h300; tg[2] = 32'h400; tg[3] = 32'hFFFF_FFFE;
        #12 nRST = 1'b1;
        repeat (10) idle();
        // Correct taken prediction.
        push(32'h100, 1, 32'h200, 0);
        resolve(1, 32'h200);
        // Predicted NT, actually taken.
        push(32'h104, 0, 32'h0, 1);
        resolve(1, 32'h300);
        push(32'h104, 0, 32'h0, 1);
        resolve(0, 32'h0);
        // Predicted taken, actually NT: redirect to fall-through.
        push(32'h108, 1, 32'h400, 0);
        resolve(0, 32'h0);
        idle();
        // Fill, overflow push, push+resolve across wrap.
        for (int i = 0; i < 5; i++) push(32'h1000 + 4*i, 1, 32'h2000 + i, 0);
        resolve(1, 32'h2000);
        for (int i = 0; i < 6; i++)
            step(1, 32'h3000 + 4*i, 1, 32'h4000 + i, i[0], 1, 1, (i < 3) ? 32'h2001 + i : 32'h4000 + i - 3, 0);
        for (int i = 0; i < 3; i++) resolve(1, 32'h4003 + i);
        idle();
        // Underflow, then flush with push at count=3, then flush+resolve.
        resolve(1, 32'h123);
        for (int i = 0; i < 3; i++) push(32'h500 + 4*i, 0, 0, 0);
        step(1, 32'h600, 0, 0, 0, 0, 0, 0, 1);
        push(32'h700, 1, 32'h800, 0);
        step(1, 32'h704, 0, 0, 0, 1, 1, 32'h800, 1);
        idle();
        // Reset in the middle of operation.
        push(32'h900, 1, 32'h904, 0);
        push(32'h910, 0, 32'h0, 0);
        idle();
        @(negedge CLK);
        nRST = 1'b0;
        push_valid = 0; resolve_valid = 0; flush = 0;
        #1;
        chk("rst_count", {29'b0, count}, 0);
        chk("rst_push_ready", {31'b0, push_ready}, 1);
        chk("rst_update", {31'b0, update_predictor}, 0);
        mq.delete();
        @(negedge CLK);
        nRST = 1'b1;
        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 99) < 60, $urandom_range(0, 255) << 2, 1'($urandom),
                 tg[$urandom_range(0, 3)], 1'($urandom),
                 $urandom_range(0, 99) < 45, 1'($urandom), tg[$urandom_range(0, 3)],
                 $urandom_range(0, 99) < 3);
        end
        repeat (3) idle();
        chk("pending_responses", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
